// File: rtl/beta_mc_control.sv
`default_nettype none
//============================================================================
// Module   : beta_mc_control
// Brief    : Multicycle fetch/execute/memory control unit for the Beta datapath
// Revision : 1.0 - initial release
//============================================================================
module beta_mc_control #(
    parameter int ENABLE_MUL      = 1,
    parameter int MUL_CYCLES      = 4,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       irq,
    input  logic       z,
    input  logic       supervisor,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       werf,
    output logic [3:0] alufn,
    output logic       asel,
    output logic       bsel,
    output logic       moe,
    output logic       mwr,
    output logic [2:0] pcsel,
    output logic       ra2sel,
    output logic       wasel,
    output logic [1:0] wdsel,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    localparam logic [3:0] c_mul_last = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] c_alu_and  = 4'b1000;
    localparam logic [2:0] c_pc_inc   = 3'd0;
    localparam logic [2:0] c_pc_br    = 3'd1;
    localparam logic [2:0] c_pc_jmp   = 3'd2;
    localparam logic [2:0] c_pc_illop = 3'd3;
    localparam logic [2:0] c_pc_xadr  = 3'd4;
    localparam logic [1:0] c_wd_alu   = 2'd1;
    localparam logic [1:0] c_wd_mem   = 2'd2;
    localparam logic [5:0] c_op_ld    = 6'b011000;
    localparam logic [5:0] c_op_st    = 6'b011001;
    localparam logic [5:0] c_op_jmp   = 6'b011011;
    localparam logic [5:0] c_op_beq   = 6'b011100;
    localparam logic [5:0] c_op_bne   = 6'b011101;
    localparam logic [5:0] c_op_ldr   = 6'b011111;

    state_t     r_state;
    state_t     w_next;
    state_t     w_boundary;
    logic [3:0] r_mul_cnt;
    logic       w_irq_s;
    logic       w_alu_ill;
    logic       w_is_alu;
    logic       w_is_mul;
    logic       w_mul_last;
    logic       w_is_ld;
    logic       w_is_ldr;
    logic       w_is_st;
    logic       w_is_jmp;
    logic       w_is_beq;
    logic       w_is_bne;

    generate
        if (IRQ_SYNC_STAGES == 1) begin : g_sync_single
            logic r_sync;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync <= 1'b0;
                else     r_sync <= irq;
            end
            assign w_irq_s = r_sync;
        end else begin : g_sync_chain
            logic [IRQ_SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync <= '0;
                else     r_sync <= {r_sync[IRQ_SYNC_STAGES-2:0], irq};
            end
            assign w_irq_s = r_sync[IRQ_SYNC_STAGES-1];
        end
    endgenerate

    // OP/OPC space minus the unimplemented DIV slot, the x111 holes and MUL when absent
    assign w_alu_ill  = (opcode[3:0] == 4'b0011) || (opcode[2:0] == 3'b111) ||
                        ((opcode[3:0] == 4'b0010) && (ENABLE_MUL == 0));
    assign w_is_alu   = opcode[5] && !w_alu_ill;
    assign w_is_mul   = w_is_alu && (opcode[3:0] == 4'b0010);
    assign w_mul_last = !w_is_mul || (r_mul_cnt == c_mul_last);
    assign w_is_ld    = (opcode == c_op_ld);
    assign w_is_ldr   = (opcode == c_op_ldr);
    assign w_is_st    = (opcode == c_op_st);
    assign w_is_jmp   = (opcode == c_op_jmp);
    assign w_is_beq   = (opcode == c_op_beq);
    assign w_is_bne   = (opcode == c_op_bne);

    // Instruction boundary: a pending unmasked interrupt replaces the fetch
    assign w_boundary = (w_irq_s && !supervisor) ? S_TRAP : S_FETCH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mul_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_EXEC) && w_is_mul && !w_mul_last)
                r_mul_cnt <= r_mul_cnt + 4'd1;
            else
                r_mul_cnt <= '0;
        end
    end

    assign busy = (r_state != S_IDLE);

    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        werf    = 1'b0;
        alufn   = 4'b0000;
        asel    = 1'b0;
        bsel    = 1'b0;
        moe     = 1'b0;
        mwr     = 1'b0;
        pcsel   = c_pc_inc;
        ra2sel  = 1'b0;
        wasel   = 1'b0;
        wdsel   = 2'd0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                moe     = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    alufn = opcode[3:0];
                    bsel  = opcode[4];
                    wdsel = c_wd_alu;
                    if (w_mul_last) begin
                        werf   = 1'b1;
                        pc_we  = 1'b1;
                        w_next = w_boundary;
                    end
                end else if (w_is_ld) begin
                    bsel   = 1'b1;
                    w_next = S_MEM;
                end else if (w_is_ldr) begin
                    asel   = 1'b1;
                    alufn  = c_alu_and;
                    w_next = S_MEM;
                end else if (w_is_st) begin
                    bsel   = 1'b1;
                    ra2sel = 1'b1;
                    w_next = S_MEM;
                end else if (w_is_jmp || w_is_beq || w_is_bne) begin
                    if (w_is_jmp)      pcsel = c_pc_jmp;
                    else if (w_is_beq) pcsel = z ? c_pc_br : c_pc_inc;
                    else               pcsel = z ? c_pc_inc : c_pc_br;
                    werf   = 1'b1;
                    pc_we  = 1'b1;
                    w_next = w_boundary;
                end else begin
                    pcsel  = c_pc_illop;
                    wasel  = 1'b1;
                    werf   = 1'b1;
                    pc_we  = 1'b1;
                    w_next = w_boundary;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (w_is_st) begin
                    bsel   = 1'b1;
                    ra2sel = 1'b1;
                    mwr    = 1'b1;
                    if (mem_ready) begin
                        pc_we  = 1'b1;
                        w_next = w_boundary;
                    end
                end else begin
                    moe   = 1'b1;
                    wdsel = c_wd_mem;
                    if (w_is_ldr) begin
                        asel  = 1'b1;
                        alufn = c_alu_and;
                    end else begin
                        bsel  = 1'b1;
                    end
                    if (mem_ready) begin
                        werf   = 1'b1;
                        pc_we  = 1'b1;
                        w_next = w_boundary;
                    end
                end
            end
            S_TRAP: begin
                pcsel  = c_pc_xadr;
                wasel  = 1'b1;
                werf   = 1'b1;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_beta_mc_control.sv
`default_nettype none
//============================================================================
// Module   : tb_beta_mc_control
// Brief    : Self-checking bench for beta_mc_control (instruction-level model)
// Revision : 1.0 - initial release
//============================================================================
module tb_beta_mc_control;

    localparam int MUL_CYCLES      = 4;
    localparam int IRQ_SYNC_STAGES = 2;
    localparam int K_OP = 0, K_MUL = 1, K_LD = 2, K_LDR = 3, K_ST = 4;
    localparam int K_JMP = 5, K_BEQ = 6, K_BNE = 7, K_ILL = 8;

    typedef struct packed {
        logic       mem_req;
        logic       ir_we;
        logic       pc_we;
        logic       werf;
        logic [3:0] alufn;
        logic       asel;
        logic       bsel;
        logic       moe;
        logic       mwr;
        logic [2:0] pcsel;
        logic       ra2sel;
        logic       wasel;
        logic [1:0] wdsel;
        logic       busy;
    } outv_t;

    logic       clk, rst;
    logic [5:0] opcode;
    logic       irq, z, supervisor, mem_ready;
    logic       mem_req, ir_we, pc_we, werf, asel, bsel, moe, mwr, ra2sel, wasel, busy;
    logic [3:0] alufn;
    logic [2:0] pcsel;
    logic [1:0] wdsel;

    logic [5:0] opcode2;
    logic       irq2, z2, supervisor2, mem_ready2;
    logic       mem_req2, ir_we2, pc_we2, werf2, asel2, bsel2, moe2, mwr2, ra2sel2, wasel2, busy2;
    logic [3:0] alufn2;
    logic [2:0] pcsel2;
    logic [1:0] wdsel2;

    outv_t act, act2, exp_o, last_act, last_act2;
    outv_t snap_exec_first, snap_exec_last, snap_mem, snap_trap, snap2_exec;
    logic  exp_valid;
    logic  irq_req, sup_req, trap_pend;
    logic  irq_log [0:4095];
    int    cyc, n_cmp, n_bad;

    beta_mc_control #(.ENABLE_MUL(1), .MUL_CYCLES(MUL_CYCLES), .IRQ_SYNC_STAGES(IRQ_SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .irq(irq), .z(z), .supervisor(supervisor),
        .mem_ready(mem_ready), .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .werf(werf),
        .alufn(alufn), .asel(asel), .bsel(bsel), .moe(moe), .mwr(mwr), .pcsel(pcsel),
        .ra2sel(ra2sel), .wasel(wasel), .wdsel(wdsel), .busy(busy));

    beta_mc_control #(.ENABLE_MUL(0), .MUL_CYCLES(MUL_CYCLES), .IRQ_SYNC_STAGES(IRQ_SYNC_STAGES)) dut_nomul (
        .clk(clk), .rst(rst), .opcode(opcode2), .irq(irq2), .z(z2), .supervisor(supervisor2),
        .mem_ready(mem_ready2), .mem_req(mem_req2), .ir_we(ir_we2), .pc_we(pc_we2), .werf(werf2),
        .alufn(alufn2), .asel(asel2), .bsel(bsel2), .moe(moe2), .mwr(mwr2), .pcsel(pcsel2),
        .ra2sel(ra2sel2), .wasel(wasel2), .wdsel(wdsel2), .busy(busy2));

    assign act  = {mem_req, ir_we, pc_we, werf, alufn, asel, bsel, moe, mwr,
                   pcsel, ra2sel, wasel, wdsel, busy};
    assign act2 = {mem_req2, ir_we2, pc_we2, werf2, alufn2, asel2, bsel2, moe2, mwr2,
                   pcsel2, ra2sel2, wasel2, wdsel2, busy2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int classify(input logic [5:0] op, input bit en_mul);
        if (op[5]) begin
            if (op[3:0] == 4'b0011 || op[2:0] == 3'b111) return K_ILL;
            if (op[3:0] == 4'b0010) return en_mul ? K_MUL : K_ILL;
            return K_OP;
        end
        case (op)
            6'b011000: return K_LD;
            6'b011111: return K_LDR;
            6'b011001: return K_ST;
            6'b011011: return K_JMP;
            6'b011100: return K_BEQ;
            6'b011101: return K_BNE;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic bit is_mem(input int k);
        return (k == K_LD) || (k == K_LDR) || (k == K_ST);
    endfunction

    // ALU operand setup shared by the address cycle and the memory cycles
    function automatic outv_t addr_ctl(input int k);
        outv_t e;
        e = '0;
        e.busy = 1'b1;
        if (k == K_LDR) begin
            e.asel = 1'b1; e.alufn = 4'b1000;
        end else begin
            e.bsel = 1'b1;
        end
        if (k == K_ST) e.ra2sel = 1'b1;
        return e;
    endfunction

    function automatic outv_t exec_exp(input logic [5:0] op, input int k, input logic zv, input bit fin);
        outv_t e;
        e = '0;
        e.busy = 1'b1;
        case (k)
            K_OP, K_MUL: begin
                e.alufn = op[3:0]; e.bsel = op[4]; e.wdsel = 2'd1;
                e.werf = fin; e.pc_we = fin;
            end
            K_LD, K_LDR, K_ST: e = addr_ctl(k);
            K_JMP: begin e.pcsel = 3'd2; e.werf = 1'b1; e.pc_we = 1'b1; end
            K_BEQ: begin e.pcsel = zv ? 3'd1 : 3'd0; e.werf = 1'b1; e.pc_we = 1'b1; end
            K_BNE: begin e.pcsel = zv ? 3'd0 : 3'd1; e.werf = 1'b1; e.pc_we = 1'b1; end
            default: begin e.pcsel = 3'd3; e.wasel = 1'b1; e.werf = 1'b1; e.pc_we = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic outv_t mem_exp(input int k, input bit rdy);
        outv_t e;
        e = addr_ctl(k);
        e.mem_req = 1'b1;
        if (k == K_ST) begin
            e.mwr = 1'b1; e.pc_we = rdy;
        end else begin
            e.moe = 1'b1; e.wdsel = 2'd2; e.werf = rdy; e.pc_we = rdy;
        end
        return e;
    endfunction

    function automatic logic model_irq_s(input int c);
        return (c >= IRQ_SYNC_STAGES) ? irq_log[c - IRQ_SYNC_STAGES] : 1'b0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_valid) begin
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got=%05h expected=%05h", cyc, act, exp_o);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc_begin();
        @(posedge clk);
        #1;
        cyc++;
        irq        = irq_req;
        supervisor = sup_req;
    endtask

    task automatic check_cycle(input outv_t e);
        exp_o     = e;
        exp_valid = 1'b1;
        if (cyc < 4096) irq_log[cyc] = irq;
        #1;
        last_act  = act;
        last_act2 = act2;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        trap_pend = 1'b0;
        check_cycle('0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic zv, input int fw, input int mw);
        outv_t e;
        int    k, nexec;
        k = classify(op, 1'b1);
        if (trap_pend) begin
            cyc_begin();
            mem_ready = 1'b1;
            e = '0; e.busy = 1'b1; e.pcsel = 3'd4; e.wasel = 1'b1; e.werf = 1'b1; e.pc_we = 1'b1;
            check_cycle(e);
            snap_trap = last_act;
            trap_pend = 1'b0;
        end
        for (int i = 0; i <= fw; i++) begin
            cyc_begin();
            if (i == 0) opcode = op;
            mem_ready = (i == fw);
            e = '0; e.busy = 1'b1; e.mem_req = 1'b1; e.moe = 1'b1; e.ir_we = (i == fw);
            check_cycle(e);
        end
        nexec = (k == K_MUL) ? MUL_CYCLES : 1;
        for (int i = 0; i < nexec; i++) begin
            cyc_begin();
            z = zv;
            mem_ready = 1'b0;
            e = exec_exp(op, k, zv, i == nexec - 1);
            if (i == nexec - 1 && !is_mem(k)) trap_pend = model_irq_s(cyc) && !supervisor;
            check_cycle(e);
            if (i == 0) begin snap_exec_first = last_act; snap2_exec = last_act2; end
            if (i == nexec - 1) snap_exec_last = last_act;
        end
        if (is_mem(k)) begin
            for (int i = 0; i <= mw; i++) begin
                cyc_begin();
                mem_ready = (i == mw);
                e = mem_exp(k, i == mw);
                if (i == mw) trap_pend = model_irq_s(cyc) && !supervisor;
                check_cycle(e);
                if (i == 0) snap_mem = last_act;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; opcode = '0; irq = 1'b0; z = 1'b0; supervisor = 1'b0; mem_ready = 1'b0;
        opcode2 = 6'b100010; irq2 = 1'b0; z2 = 1'b0; supervisor2 = 1'b0; mem_ready2 = 1'b1;
        irq_req = 1'b0; sup_req = 1'b0; trap_pend = 1'b0; exp_valid = 1'b0;
        cyc = 0; n_cmp = 0; n_bad = 0;
        for (int i = 0; i < 4096; i++) irq_log[i] = 1'b0;

        do_reset();
        lit("idle_busy", busy, 0);
        lit("idle_pcsel", pcsel, 0);

        run_instr(6'b100000, 1'b0, 0, 0);                 // ADD
        lit("add_alufn", snap_exec_first.alufn, 4'b0000);
        lit("add_werf",  snap_exec_first.werf, 1);
        lit("add_pc_we", snap_exec_first.pc_we, 1);
        lit("add_wdsel", snap_exec_first.wdsel, 1);
        lit("nomul_pcsel", snap2_exec.pcsel, 3);
        lit("nomul_wasel", snap2_exec.wasel, 1);
        lit("nomul_werf",  snap2_exec.werf, 1);

        run_instr(6'b100000, 1'b0, 2, 0);                 // ADD, slow fetch
        run_instr(6'b110001, 1'b0, 0, 0);                 // SUBC
        run_instr(6'b101110, 1'b0, 1, 0);                 // SRA
        run_instr(6'b100010, 1'b0, 0, 0);                 // MUL
        lit("mul_first_werf", snap_exec_first.werf, 0);
        lit("mul_first_pc_we", snap_exec_first.pc_we, 0);
        lit("mul_last_werf", snap_exec_last.werf, 1);
        lit("mul_last_pc_we", snap_exec_last.pc_we, 1);
        run_instr(6'b110010, 1'b0, 0, 0);                 // MULC
        run_instr(6'b011001, 1'b0, 0, 3);                 // ST, 3 wait cycles
        lit("st_mwr",   snap_mem.mwr, 1);
        lit("st_pc_we", snap_mem.pc_we, 0);
        lit("st_ra2sel", snap_mem.ra2sel, 1);
        run_instr(6'b011000, 1'b0, 0, 1);                 // LD
        run_instr(6'b011111, 1'b0, 1, 0);                 // LDR
        run_instr(6'b011100, 1'b1, 0, 0);                 // BEQ taken
        lit("beq_z1_pcsel", snap_exec_first.pcsel, 1);
        run_instr(6'b011100, 1'b0, 0, 0);                 // BEQ not taken
        lit("beq_z0_pcsel", snap_exec_first.pcsel, 0);
        lit("beq_z0_werf", snap_exec_first.werf, 1);
        run_instr(6'b011101, 1'b1, 0, 0);                 // BNE
        run_instr(6'b011101, 1'b0, 0, 0);
        run_instr(6'b011011, 1'b0, 0, 0);                 // JMP
        run_instr(6'b000000, 1'b0, 0, 0);                 // illegal opcodes
        run_instr(6'b100011, 1'b0, 0, 0);
        run_instr(6'b100111, 1'b0, 0, 0);
        run_instr(6'b011010, 1'b0, 0, 0);
        run_instr(6'b110111, 1'b0, 0, 0);

        // interrupt raised during LD, taken after it completes
        irq_req = 1'b1;
        run_instr(6'b011000, 1'b0, 0, 0);
        sup_req = 1'b1;
        run_instr(6'b100000, 1'b0, 0, 0);
        lit("trap_pcsel", snap_trap.pcsel, 4);
        lit("trap_wasel", snap_trap.wasel, 1);
        lit("trap_werf",  snap_trap.werf, 1);
        run_instr(6'b011000, 1'b0, 0, 0);                 // masked while supervisor
        irq_req = 1'b0;
        run_instr(6'b100000, 1'b0, 0, 0);
        sup_req = 1'b0;
        run_instr(6'b100000, 1'b0, 0, 0);

        // reset in the middle of a stalled store
        cyc_begin();
        opcode = 6'b011001; mem_ready = 1'b1;
        check_cycle({1'b1, 1'b1, 2'b00, 4'd0, 2'b00, 1'b1, 1'b0, 3'd0, 2'b00, 2'd0, 1'b1});
        cyc_begin();
        mem_ready = 1'b0;
        check_cycle(exec_exp(6'b011001, K_ST, 1'b0, 1'b1));
        for (int i = 0; i < 2; i++) begin
            cyc_begin();
            mem_ready = 1'b0;
            check_cycle(mem_exp(K_ST, 1'b0));
        end
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        lit("async_mwr", mwr, 0);
        lit("async_mem_req", mem_req, 0);
        lit("async_busy", busy, 0);
        do_reset();
        run_instr(6'b100000, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
